// File: rtl/quick_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package : quick_uart_pkg
//  Shared types for the quick_uart block set: parity selection, receiver
//  state encoding and the per-word receive status bundle.
//  Revision: 1.0 - initial release
// ============================================================================
package quick_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Status travelling with each received word through the output FIFO.
    typedef struct packed {
        logic dropped;
        logic parity_err;
        logic frame_err;
        logic brk;
    } rx_status_t;

endpackage
`default_nettype wire

// File: rtl/quick_uart_rx_ex_if.sv
`default_nettype none
// ============================================================================
//  Interface : quick_uart_rx_ex_if
//  Ready/valid word stream from the receiver to its consumer.
//  Signals : valid_o, data_o, data_dropped_o, parity_err_o, frame_err_o,
//            break_o (receiver -> consumer), ready_i (consumer -> receiver)
//  Modports: master = receiver side, slave = consumer side
//  Revision: 1.0 - initial release
// ============================================================================
interface quick_uart_rx_ex_if #(
    parameter int DATA_BITS = 8
);
    logic                 valid_o;
    logic                 ready_i;
    logic [DATA_BITS-1:0] data_o;
    logic                 data_dropped_o;
    logic                 parity_err_o;
    logic                 frame_err_o;
    logic                 break_o;

    modport master (
        output valid_o, data_o, data_dropped_o, parity_err_o, frame_err_o, break_o,
        input  ready_i
    );

    modport slave (
        input  valid_o, data_o, data_dropped_o, parity_err_o, frame_err_o, break_o,
        output ready_i
    );
endinterface
`default_nettype wire

// File: rtl/quick_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : quick_uart_fifo
//  Generic synchronous FIFO. Head entry is read straight from the storage
//  flops so a pop exposes the next entry on the following cycle and
//  back-to-back pops sustain one entry per clock. A push into a full FIFO is
//  accepted only when a pop happens in the same cycle.
//  Ports   : clk, rst       - clock, synchronous active-high reset
//            i_push, i_data - write request and entry
//            i_pop          - read request (ignored when empty)
//            o_full         - no free entry this cycle
//            o_valid,o_data - head entry present / head entry (0 when empty)
//  Revision: 1.0 - initial release
// ============================================================================
module quick_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic                  o_full,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit separates the full and empty cases.
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_rd    = i_pop && !w_empty;
    assign w_wr    = i_push && (!w_full || w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !rst) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

    assign o_full  = w_full;
    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/quick_uart_rx_ex.sv
`default_nettype none
// ============================================================================
//  Module  : quick_uart_rx_ex
//  UART receiver with configurable data/parity/stop bits, start-bit glitch
//  rejection, per-word framing/parity/break status and an output FIFO.
//  Ports   : clk_i, rst_i - clock, synchronous active-high reset
//            rx_i         - asynchronous serial line, idles high
//            busy_o       - a frame is in progress
//            rx_if        - ready/valid word stream (master side)
//  Revision: 1.0 - initial release
// ============================================================================
module quick_uart_rx_ex
    import quick_uart_pkg::*;
#(
    parameter int DIV        = 5,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    input  wire logic           rx_i,
    output logic                busy_o,
    quick_uart_rx_ex_if.master  rx_if
);
    localparam int c_CNT_W = $clog2(DIV + 1);
    localparam int c_ST_W  = $bits(rx_status_t);
    localparam int c_FW    = c_ST_W + DATA_BITS;

    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(DIV / 2);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DIV);

    localparam logic [2:0] c_S_IDLE   = RX_IDLE;
    localparam logic [2:0] c_S_START  = RX_START;
    localparam logic [2:0] c_S_DATA   = RX_DATA;
    localparam logic [2:0] c_S_PARITY = RX_PARITY;
    localparam logic [2:0] c_S_STOP   = RX_STOP;

    logic [1:0]           r_sync;
    logic [2:0]           r_state;
    logic                 r_armed;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_bits;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_lost;

    logic [2:0]           w_state_d;
    logic                 w_armed_d;
    logic [c_CNT_W-1:0]   w_cnt_d;
    logic [3:0]           w_bits_d;
    logic [DATA_BITS-1:0] w_shift_d;
    logic                 w_perr_d;
    logic                 w_ferr_d;
    logic                 w_lost_d;

    logic                 w_rx;
    logic                 w_tick;
    logic                 w_par_exp;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_accept;
    rx_status_t           w_push_st;
    rx_status_t           w_head_st;
    logic [c_FW-1:0]      w_head;

    assign w_rx = r_sync[1];
    // The counter is reloaded with DIV on every sample, so a value of 1
    // marks the next sample point exactly DIV cycles later.
    assign w_tick = (r_cnt == c_CNT_W'(1));

    generate
        if (PARITY == int'(PAR_ODD)) begin : g_par_odd
            assign w_par_exp = ~^r_shift;
        end else if (PARITY == int'(PAR_EVEN)) begin : g_par_even
            assign w_par_exp = ^r_shift;
        end else begin : g_par_none
            assign w_par_exp = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_d = r_state;
        w_armed_d = r_armed;
        w_cnt_d   = r_cnt;
        w_bits_d  = r_bits;
        w_shift_d = r_shift;
        w_perr_d  = r_perr;
        w_ferr_d  = r_ferr;
        w_push    = 1'b0;

        if (r_state != c_S_IDLE && !w_tick) w_cnt_d = r_cnt - c_CNT_W'(1);

        case (r_state)
            c_S_IDLE: begin
                // A line stuck low after a break must go high before the
                // next start bit is accepted.
                if (w_rx) begin
                    w_armed_d = 1'b1;
                end else if (r_armed) begin
                    w_state_d = c_S_START;
                    w_armed_d = 1'b0;
                    w_cnt_d   = c_HALF;
                end
            end
            c_S_START: begin
                if (w_tick) begin
                    if (w_rx) begin
                        w_state_d = c_S_IDLE;
                        w_armed_d = 1'b1;
                    end else begin
                        w_state_d = c_S_DATA;
                        w_cnt_d   = c_FULL;
                        w_bits_d  = '0;
                        w_perr_d  = 1'b0;
                        w_ferr_d  = 1'b0;
                    end
                end
            end
            c_S_DATA: begin
                if (w_tick) begin
                    w_shift_d = {w_rx, r_shift[DATA_BITS-1:1]};
                    w_cnt_d   = c_FULL;
                    if (r_bits == 4'(DATA_BITS - 1)) begin
                        w_bits_d  = '0;
                        w_state_d = (PARITY != int'(PAR_NONE)) ? c_S_PARITY : c_S_STOP;
                    end else begin
                        w_bits_d = r_bits + 4'd1;
                    end
                end
            end
            c_S_PARITY: begin
                if (w_tick) begin
                    w_perr_d  = (w_rx != w_par_exp);
                    w_cnt_d   = c_FULL;
                    w_state_d = c_S_STOP;
                end
            end
            c_S_STOP: begin
                if (w_tick) begin
                    w_ferr_d = r_ferr | ~w_rx;
                    w_cnt_d  = c_FULL;
                    if (r_bits == 4'(STOP_BITS - 1)) begin
                        w_push    = 1'b1;
                        w_state_d = c_S_IDLE;
                        w_armed_d = w_rx;
                        w_bits_d  = '0;
                    end else begin
                        w_bits_d = r_bits + 4'd1;
                    end
                end
            end
            default: begin
                w_state_d = c_S_IDLE;
                w_armed_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_push_st            = '0;
        w_push_st.dropped    = r_lost;
        w_push_st.parity_err = r_perr;
        w_push_st.frame_err  = w_ferr_d;
        w_push_st.brk        = w_ferr_d && (r_shift == '0);
    end

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_pop    = rx_if.valid_o && rx_if.ready_i;
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_lost_d = w_push ? !w_accept : r_lost;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync  <= 2'b11;
            r_state <= c_S_IDLE;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_lost  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx_i};
            r_state <= w_state_d;
            r_armed <= w_armed_d;
            r_cnt   <= w_cnt_d;
            r_bits  <= w_bits_d;
            r_shift <= w_shift_d;
            r_perr  <= w_perr_d;
            r_ferr  <= w_ferr_d;
            r_lost  <= w_lost_d;
        end
    end

    quick_uart_fifo #(
        .WIDTH (c_FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_data  ({w_push_st, r_shift}),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_valid (rx_if.valid_o),
        .o_data  (w_head)
    );

    assign w_head_st            = w_head[c_FW-1:DATA_BITS];
    assign rx_if.data_o         = w_head[DATA_BITS-1:0];
    assign rx_if.data_dropped_o = w_head_st.dropped;
    assign rx_if.parity_err_o   = w_head_st.parity_err;
    assign rx_if.frame_err_o    = w_head_st.frame_err;
    assign rx_if.break_o        = w_head_st.brk;
    assign busy_o               = (r_state != c_S_IDLE);

endmodule
`default_nettype wire
